// File: rtl/multi_s2f_arb.sv
// Round-robin arbiter and sequencer that feeds one slow-to-fast word channel.
// Grants one requester at a time and shapes valid_in with a fixed hold and gap.
module multi_s2f_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int HOLD_CYC   = 2,
   parameter int GAP_CYC    = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [DATA_WIDTH-1:0]           din,
   output logic                            valid_in,
   output logic [$clog2(NUM_REQ)-1:0]      src_id,
   output logic                            busy,
   output logic [CNT_WIDTH-1:0]            xfer_cnt
);

   localparam int IW   = $clog2(NUM_REQ);
   localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                r_state, w_state;
   logic [CW-1:0]         r_cnt, w_cnt;
   logic [IW-1:0]         r_ptr, w_ptr;
   logic [NUM_REQ-1:0]    r_gnt, w_gnt;
   logic [DATA_WIDTH-1:0] r_din, w_din;
   logic                  r_valid, w_valid;
   logic [IW-1:0]         r_src, w_src;
   logic                  r_busy, w_busy;
   logic [CNT_WIDTH-1:0]  r_xfer, w_xfer;
   logic [IW-1:0]         w_sel;

   // Walk downward so the lowest offset from r_ptr wins; index wraps mod NUM_REQ.
   always_comb begin
      w_sel = r_ptr;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[r_ptr + IW'(j)]) w_sel = r_ptr + IW'(j);
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_ptr   = r_ptr;
      w_gnt   = '0;
      w_din   = r_din;
      w_valid = r_valid;
      w_src   = r_src;
      w_xfer  = r_xfer;
      unique case (r_state)
         IDLE: begin
            if (en && (|req)) begin
               w_gnt   = NUM_REQ'(1) << w_sel;
               w_din   = req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
               w_valid = 1'b1;
               w_src   = w_sel;
               w_xfer  = r_xfer + CNT_WIDTH'(1);
               w_ptr   = w_sel + IW'(1);
               w_cnt   = CW'(HOLD_CYC - 1);
               w_state = HOLD;
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_valid = 1'b0;
               w_cnt   = CW'(GAP_CYC - 1);
               w_state = GAP;
            end else begin
               w_cnt = r_cnt - CW'(1);
            end
         end
         GAP: begin
            if (r_cnt == '0) w_state = IDLE;
            else             w_cnt   = r_cnt - CW'(1);
         end
         default: w_state = IDLE;
      endcase
      w_busy = (w_state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_din   <= '0;
         r_valid <= 1'b0;
         r_src   <= '0;
         r_busy  <= 1'b0;
         r_xfer  <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_ptr   <= w_ptr;
         r_gnt   <= w_gnt;
         r_din   <= w_din;
         r_valid <= w_valid;
         r_src   <= w_src;
         r_busy  <= w_busy;
         r_xfer  <= w_xfer;
      end
   end

   assign gnt      = r_gnt;
   assign din      = r_din;
   assign valid_in = r_valid;
   assign src_id   = r_src;
   assign busy     = r_busy;
   assign xfer_cnt = r_xfer;

endmodule

// File: doc/multi_s2f_arb.md
# multi_s2f_arb

Slow-domain round-robin arbiter and sequencer that shares one slow-to-fast multi-bit transfer channel among several requesters. It grants one requester at a time and drives the channel's data bus and level valid strobe. It enforces a minimum valid-high time and a minimum valid-low gap so the fast-side rising-edge detector captures every word exactly once. It sits entirely in the slow clock domain, directly ahead of the channel's `din`/`valid_in` inputs.

## Interface
- `DATA_WIDTH`, 8: width of each data word.
- `NUM_REQ`, 4: number of requesters; must be a power of two, 2..16.
- `HOLD_CYC`, 2: `valid_in` high time in clk cycles; must be at least 1.
- `GAP_CYC`, 2: minimum `valid_in` low time after each transfer; must be at least 1.
- `CNT_WIDTH`, 8: width of the transfer counter.
- `clk`  in  1  slow clock, shared with the channel's slow side.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  when 1, new grants are allowed; when 0, no new grant is issued and an in-flight transfer completes.
- `req`  in  NUM_REQ  request per requester; level, held until granted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  word k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle grant pulse.
- `din`  out  DATA_WIDTH  channel data bus.
- `valid_in`  out  1  channel valid strobe.
- `src_id`  out  clog2(NUM_REQ)  index of the last granted requester.
- `busy`  out  1  high when the state is not IDLE.
- `xfer_cnt`  out  CNT_WIDTH  count of granted transfers; wraps modulo 2^CNT_WIDTH.

## Operation
- Reset values: state=IDLE, `gnt`=0, `din`=0, `valid_in`=0, `src_id`=0, `busy`=0, `xfer_cnt`=0, round-robin pointer `ptr`=0.
- The FSM has three states: IDLE, HOLD and GAP. One down-counter serves both HOLD and GAP. All outputs are registered.
- **IDLE:**
  - Condition: `en`=1 and `req`≠0.
  - Select k = first set bit of `req`, searching from `ptr` upward with wrap.
  - Next cycle: `gnt[k]`=1, `din`=`req_data[k]`, `valid_in`=1, `src_id`=k, `xfer_cnt`+1, `ptr`=(k+1) mod NUM_REQ, counter=HOLD_CYC-1, state=HOLD.
- **HOLD:**
  - `gnt` returns to 0 after one cycle.
  - When counter=0: `valid_in`=0, counter=GAP_CYC-1, state=GAP. Otherwise decrement the counter.
- **GAP:**
  - When counter=0, go to IDLE. Otherwise decrement the counter.
  - `req` is not sampled in HOLD or GAP.
- `din` and `src_id` change only on a grant. They stay stable from the grant until the next grant, so the word is stable throughout the fast-side synchronizer delay.
- A requester must drop `req` within HOLD_CYC+GAP_CYC cycles after `gnt`, or it is granted again. A registered drop in the cycle after `gnt` always meets this.
- `req` bits that drop before being sampled in IDLE are not granted and are not latched.
- `en` is sampled only in IDLE. Changes to `en` during HOLD or GAP do not affect the in-flight transfer.
- Asynchronous reset asserted at any time: all outputs and `ptr` return to reset values immediately, any in-flight transfer is abandoned, and `valid_in` falls.

## Timing
- Latency: `req` sampled in IDLE at cycle t gives `gnt`/`valid_in` high at t+1.
- `valid_in` is high for exactly HOLD_CYC cycles, t+1..t+HOLD_CYC.
- `valid_in` is low for at least GAP_CYC+1 cycles between transfers.
- Back-to-back grant period: HOLD_CYC+GAP_CYC+1 cycles, which is 5 with the default parameters.
- `gnt` coincides with the first cycle of `valid_in`.
- `busy` is high from t+1 through the last GAP cycle.
- `xfer_cnt` at 2^CNT_WIDTH-1 wraps to 0 on the next grant.

## Test plan
- Reset: drive `rst_n`=0 while `req`=4'hF. All outputs stay at 0 and no `gnt` is issued. Release reset. First grant is `gnt`=4'b0001.
- Single transfer, defaults: `req[1]` rises with `req_data[1]`=8'hA5 at IDLE cycle 0.
  - Cycle 1: `gnt`=4'b0010, `din`=8'hA5, `src_id`=1, `xfer_cnt`=1.
  - `valid_in` is high in cycles 1-2 and low in cycles 3-4; `busy` is low at cycle 5.
  - `din` holds 8'hA5 afterwards.
- Fairness: hold `req`=4'hF continuously. Grants go 0,1,2,3,0 at cycles 1, 6, 11, 16, 21.
- Pointer rotation: after a grant to requester 2, raise `req`=4'b1001. Requester 3 is granted, then requester 0.
- Enable control:
  - `en`=0 with `req[0]`=1 for 10 cycles gives no `gnt`.
  - `en` dropping during HOLD: the transfer still completes with the full HOLD and GAP, then no new grant follows.
- Reset mid-transfer: assert `rst_n`=0 during HOLD. `valid_in`, `din` and `xfer_cnt` go to 0 without waiting for `clk`. After release, arbitration restarts at requester 0.
- Counter wrap: with CNT_WIDTH=8, the 256th grant gives `xfer_cnt`=0.
